// File: rtl/frame_read_pkg.sv
// frame_read_pkg: shared types and constants for the frame read sequencer.
//   state_e        : sequencer state (IDLE, REQ)
//   REQ_LEN_W      : width of the req_len output
//   burst_cfg_ok() : true when a line is a whole number of bursts
package frame_read_pkg;
    typedef enum logic {IDLE, REQ} state_e;
    localparam int REQ_LEN_W = 16;
    function automatic bit burst_cfg_ok(input int line_bytes, input int burst_bytes);
        return burst_bytes > 0 && line_bytes >= burst_bytes && line_bytes % burst_bytes == 0;
    endfunction
endpackage

// File: rtl/frame_read_sequencer.sv
// frame_read_sequencer: walks one framebuffer per frame_start, issuing burst reads line by line.
//   clk, rst_n                 : memory-domain clock, async active-low reset
//   frame_start, enable        : start pulse (ignored when enable is low)
//   base_addr, line_stride     : frame geometry, sampled on each seen frame_start
//   req_valid/req_ready        : burst request handshake; req_addr/req_len describe the burst
//   busy, frame_done           : frame in progress, one-cycle completion pulse
//   overrun, clr_overrun       : sticky "start while busy" flag and its synchronous clear
module frame_read_sequencer
    import frame_read_pkg::*;
#(
    parameter int LINES       = 720,
    parameter int LINE_BYTES  = 5120,
    parameter int BURST_BYTES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    line_stride,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [REQ_LEN_W-1:0] req_len,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    localparam int BPL  = LINE_BYTES / BURST_BYTES;
    localparam int BC_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int LC_W = (LINES > 1) ? $clog2(LINES) : 1;

    if (!burst_cfg_ok(LINE_BYTES, BURST_BYTES) || LINES < 1) begin : g_bad_cfg
        $error("frame_read_sequencer: LINE_BYTES must be a multiple of BURST_BYTES and LINES >= 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] line_start_q, line_start_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] pend_base_q, pend_base_d;
    logic [ADDR_W-1:0] pend_stride_q, pend_stride_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              start_ok, hs, last_burst, last_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            line_start_q  <= '0;
            stride_q      <= '0;
            pend_base_q   <= '0;
            pend_stride_q <= '0;
            burst_cnt_q   <= '0;
            line_cnt_q    <= '0;
            pend_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            line_start_q  <= line_start_d;
            stride_q      <= stride_d;
            pend_base_q   <= pend_base_d;
            pend_stride_q <= pend_stride_d;
            burst_cnt_q   <= burst_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pend_q        <= pend_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        line_start_d  = line_start_q;
        stride_d      = stride_q;
        pend_base_d   = pend_base_q;
        pend_stride_d = pend_stride_q;
        burst_cnt_d   = burst_cnt_q;
        line_cnt_d    = line_cnt_q;
        pend_d        = pend_q;
        done_d        = 1'b0;
        start_ok      = frame_start & enable;
        hs            = (state_q == REQ) & req_ready;
        last_burst    = burst_cnt_q == BC_W'(BPL - 1);
        last_line     = line_cnt_q == LC_W'(LINES - 1);
        // Any start seen while a frame runs is an overrun, even if enable is low.
        overrun_d     = (frame_start & (state_q == REQ)) | (overrun_q & ~clr_overrun);
        if (state_q == IDLE) begin
            if (start_ok) begin
                state_d      = REQ;
                req_addr_d   = base_addr;
                line_start_d = base_addr;
                stride_d     = line_stride;
                burst_cnt_d  = '0;
                line_cnt_d   = '0;
            end
        end else begin
            // Latest start while busy wins; it takes effect at the next handshake.
            if (start_ok) begin
                pend_d        = 1'b1;
                pend_base_d   = base_addr;
                pend_stride_d = line_stride;
            end
            if (hs) begin
                if (pend_d) begin
                    req_addr_d   = pend_base_d;
                    line_start_d = pend_base_d;
                    stride_d     = pend_stride_d;
                    burst_cnt_d  = '0;
                    line_cnt_d   = '0;
                    pend_d       = 1'b0;
                end else if (last_burst && last_line) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (last_burst) begin
                    burst_cnt_d  = '0;
                    line_cnt_d   = line_cnt_q + 1'b1;
                    line_start_d = line_start_q + stride_q;
                    req_addr_d   = line_start_q + stride_q;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    req_addr_d  = req_addr_q + ADDR_W'(BURST_BYTES);
                end
            end
        end
    end

    assign req_valid  = state_q == REQ;
    assign busy       = state_q != IDLE;
    assign req_addr   = req_addr_q;
    assign req_len    = REQ_LEN_W'(BURST_BYTES);
    assign frame_done = done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_frame_read_sequencer.sv
// tb_frame_read_sequencer: directed + random stimulus checked against a frame-index reference model.
module tb_frame_read_sequencer;
    localparam int LINES = 2, LB = 512, BB = 256, AW = 16;
    localparam int BPL = LB / BB, TOTAL = LINES * BPL;

    logic clk = 0, rst_n = 0;
    logic frame_start = 0, enable = 1, req_ready = 0, clr_overrun = 0;
    logic [AW-1:0] base_addr = 0, line_stride = 0;
    logic req_valid, busy, frame_done, overrun;
    logic [AW-1:0] req_addr;
    logic [15:0] req_len;

    frame_read_sequencer #(.LINES(LINES), .LINE_BYTES(LB), .BURST_BYTES(BB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
        .base_addr(base_addr), .line_stride(line_stride), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is "burst index k of TOTAL" on a base/stride pair.
    bit m_active, m_pend, m_done, m_ovr;
    int m_k;
    logic [AW-1:0] m_base, m_stride, m_pbase, m_pstride;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pend = 0; m_done = 0; m_ovr = 0; m_k = 0;
        end else begin
            bit hs, was_busy;
            was_busy = m_active;
            hs = m_active && req_ready;
            m_done = 0;
            m_ovr = (frame_start && was_busy) || (m_ovr && !clr_overrun);
            if (!was_busy) begin
                if (frame_start && enable) begin
                    m_active = 1; m_base = base_addr; m_stride = line_stride; m_k = 0;
                end
            end else begin
                if (frame_start && enable) begin
                    m_pend = 1; m_pbase = base_addr; m_pstride = line_stride;
                end
                if (hs) begin
                    if (m_pend) begin
                        m_pend = 0; m_base = m_pbase; m_stride = m_pstride; m_k = 0;
                    end else if (m_k == TOTAL - 1) begin
                        m_active = 0; m_done = 1;
                    end else m_k++;
                end
            end
        end
    end

    function automatic logic [AW-1:0] model_addr();
        int a;
        a = int'(m_base) + (m_k / BPL) * int'(m_stride) + (m_k % BPL) * BB;
        return AW'(a);
    endfunction

    logic [AW-1:0] hs_log[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_valid", 32'(req_valid), 32'(m_active));
            chk("busy", 32'(busy), 32'(m_active));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("req_len", 32'(req_len), 32'(BB));
            if (m_active) chk("req_addr", 32'(req_addr), 32'(model_addr()));
            if (req_valid && req_ready) hs_log.push_back(req_addr);
            if (frame_done) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] s);
        frame_start = 1; base_addr = b; line_stride = s;
        cyc(1);
        frame_start = 0;
    endtask

    task automatic chk_log(input string name, input logic [AW-1:0] e[6], input int n);
        chk({name, "_count"}, 32'(hs_log.size()), 32'(n));
        for (int i = 0; i < n && i < hs_log.size(); i++) chk(name, 32'(hs_log[i]), 32'(e[i]));
    endtask

    task automatic clear_log();
        hs_log.delete();
        done_cnt = 0;
    endtask

    initial begin
        #2;
        chk("reset_valid", 32'(req_valid), 0);
        chk("reset_addr", 32'(req_addr), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ovr", 32'(overrun), 0);
        cyc(2);
        rst_n = 1;
        cyc(1);

        // Basic frame
        req_ready = 1; clear_log();
        start(16'h1000, 16'h0800);
        cyc(6);
        chk_log("basic", '{16'h1000, 16'h1100, 16'h1800, 16'h1900, 0, 0}, 4);
        chk("basic_done", done_cnt, 1);

        // Backpressure on second request
        clear_log();
        start(16'h1000, 16'h0800);
        cyc(1);
        req_ready = 0;
        cyc(3);
        chk("bp_hold_addr", 32'(req_addr), 32'h1100);
        chk("bp_hold_valid", 32'(req_valid), 1);
        req_ready = 1;
        cyc(6);
        chk_log("bp", '{16'h1000, 16'h1100, 16'h1800, 16'h1900, 0, 0}, 4);

        // Address wrap
        clear_log();
        start(16'hFF00, 16'h0200);
        cyc(6);
        chk_log("wrap", '{16'hFF00, 16'h0000, 16'h0100, 16'h0200, 0, 0}, 4);

        // Overrun with restart during the second request
        clear_log();
        start(16'h1000, 16'h0800);
        cyc(1);
        start(16'h4000, 16'h0800);
        chk("ovr_set", 32'(overrun), 1);
        cyc(7);
        chk_log("restart", '{16'h1000, 16'h1100, 16'h4000, 16'h4100, 16'h4800, 16'h4900}, 6);
        chk("restart_done", done_cnt, 1);
        clr_overrun = 1;
        cyc(1);
        clr_overrun = 0;
        chk("ovr_clr", 32'(overrun), 0);

        // Gating
        clear_log(); enable = 0;
        start(16'h3000, 16'h0100);
        cyc(3);
        chk("gate_busy", 32'(busy), 0);
        chk("gate_ovr", 32'(overrun), 0);
        chk("gate_log", 32'(hs_log.size()), 0);
        enable = 1;

        // Reset mid-frame
        req_ready = 0;
        start(16'h1000, 16'h0800);
        cyc(1);
        rst_n = 0;
        #1;
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(req_addr), 0);
        cyc(1);
        rst_n = 1; req_ready = 1; clear_log();
        start(16'h2000, 16'h0400);
        cyc(6);
        chk_log("post_rst", '{16'h2000, 16'h2100, 16'h2400, 16'h2500, 0, 0}, 4);

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            req_ready   = $urandom_range(0, 3) != 0;
            frame_start = $urandom_range(0, 11) == 0;
            enable      = $urandom_range(0, 9) != 0;
            clr_overrun = $urandom_range(0, 15) == 0;
            base_addr   = AW'($urandom);
            line_stride = AW'($urandom);
            cyc(1);
        end
        frame_start = 0; clr_overrun = 0; req_ready = 1;
        cyc(20);
        chk("drain_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
